aesl_deadlock_confirm: RTL and testbench
========================================

AESL_DEADLOCK_CONFIRM -- requirements
Module: aesl_deadlock_confirm

Interface
REQ-001 Parameter: THRESHOLD, default 16; number of consecutive cycles `block_in` must stay high before a deadlock is confirmed; legal range 2..65535.
REQ-002 Parameter: TS_W, default 32; width of the free-running cycle timestamp.
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 block_in  input  1  raw per-cycle deadlock indication from the upstream deadlock monitor.
REQ-006 axis_vec_in  input  8  per-process AXIS-block vector; bit i = process i is stalled on a stream.
REQ-007 chan_vec_in  input  8  per-process channel-block vector; bit i = process i is stalled on a FIFO or PIPO.
REQ-008 clear  input  1  synchronous clear of the sticky result; returns the FSM to IDLE.
REQ-009 report_ready  input  1  testbench consumer ready for the report.
REQ-010 deadlock  output  1  sticky confirmed-deadlock flag.
REQ-011 report_valid  output  1  report available.
REQ-012 report_axis_vec  output  8  captured copy of axis_vec_in.
REQ-013 report_chan_vec  output  8  captured copy of chan_vec_in.
REQ-014 report_start_ts  output  TS_W  timestamp of the first cycle of the confirmed block episode.
REQ-015 glitch_count  output  8  saturating count of block episodes that ended before confirmation.

Function
REQ-016 `ts` is a TS_W counter; it increments every cycle and wraps modulo 2^TS_W.
REQ-017 FSM states are IDLE, SUSPECT, REPORT and HALT.
REQ-018 IDLE transitions:
- block_in=1 → SUSPECT.
- On that transition: run counter `run` := 1; `ts` is latched into the start register.
REQ-019 SUSPECT transitions:
- block_in=1 and run < THRESHOLD-1 → run increments by 1.
- block_in=1 and run = THRESHOLD-1 → REPORT; axis_vec_in and chan_vec_in are captured in the same cycle.
- block_in=0 → IDLE; glitch_count increments by 1 and saturates at 255.
REQ-020 Confirmation latency: block_in high for THRESHOLD consecutive cycles (edges N..N+THRESHOLD-1) → deadlock=1 and report_valid=1 from edge N+THRESHOLD-1 onward.
REQ-021 REPORT state:
- report_valid=1.
- Report outputs are stable and do not track their inputs.
- report_valid and report_ready both 1 at an edge → HALT.
REQ-022 HALT state:
- report_valid=0; deadlock stays 1.
- block_in is ignored.
- Report outputs keep their captured values.
REQ-023 deadlock is set on entry to REPORT and cleared only by reset or by clear.
REQ-024 clear=1 in any state, at the next edge:
- FSM → IDLE; deadlock, report_valid and run cleared.
- Report registers and glitch_count cleared.
- clear takes priority over every other transition in the same cycle.
REQ-025 clear=1 together with block_in=1 → IDLE for that cycle; a new episode starts no earlier than the following cycle.
REQ-026 report_ready is ignored in all states except REPORT.
REQ-027 report_valid, once asserted, remains asserted until the handshake, clear or reset.
REQ-028 All outputs are driven from registers only; there are no combinational paths from input to output.

Reset
REQ-029 reset_n=0 forces, asynchronously:
- FSM = IDLE; ts = 0; run = 0.
- deadlock = 0; report_valid = 0.
- report_axis_vec = 0; report_chan_vec = 0; report_start_ts = 0.
- glitch_count = 0.
REQ-030 Reset asserted mid-episode, in any state, discards the episode; reset does not increment glitch_count.
REQ-031 After reset_n deasserts, the first edge is normal operation; ts=1 after that edge.

Verification
REQ-032 THRESHOLD=16; block_in high from ts=10 for 16 cycles; axis_vec_in=8'h81, chan_vec_in=8'h7E → report_valid=1 and deadlock=1 after edge at ts=25; report_start_ts=10; report_axis_vec=8'h81; report_chan_vec=8'h7E.
REQ-033 block_in high for 15 cycles, then low → no report; glitch_count=1; FSM back in IDLE.
REQ-034 300 glitch episodes of 3 cycles each → glitch_count=255 (saturated); deadlock=0.
REQ-035 Confirmed report with report_ready held low for 50 cycles while vectors change → report_valid stays 1 and captured values are unchanged; report_ready=1 for one cycle → report_valid=0, deadlock=1, state HALT.
REQ-036 clear asserted while in HALT → deadlock=0 and all report fields 0 at the next edge; new 16-cycle block episode → second report with a new report_start_ts.
REQ-037 reset_n pulsed low at run=12 → all outputs 0 immediately (before the next clock edge); glitch_count=0; re-confirmation requires 16 full cycles after reset release.

Source files
------------

// File: rtl/aesl_deadlock_confirm.sv
// Deadlock confirmation filter: a block indication must persist for THRESHOLD
// consecutive cycles before a sticky deadlock and a one-shot report are raised.
module aesl_deadlock_confirm #(
    parameter int unsigned THRESHOLD = 16,
    parameter int unsigned TS_W      = 32
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            block_in,
    input  logic [7:0]      axis_vec_in,
    input  logic [7:0]      chan_vec_in,
    input  logic            clear,
    input  logic            report_ready,
    output logic            deadlock,
    output logic            report_valid,
    output logic [7:0]      report_axis_vec,
    output logic [7:0]      report_chan_vec,
    output logic [TS_W-1:0] report_start_ts,
    output logic [7:0]      glitch_count
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SUSPECT = 2'd1,
        ST_REPORT  = 2'd2,
        ST_HALT    = 2'd3
    } state_t;

    localparam logic [15:0]     RUN_LAST = 16'(THRESHOLD - 1);
    localparam logic [TS_W-1:0] TS_ONE   = {{(TS_W-1){1'b0}}, 1'b1};

    state_t          r_state;
    logic [TS_W-1:0] r_ts;
    logic [15:0]     r_run;
    logic            r_deadlock;
    logic            r_report_valid;
    logic [7:0]      r_axis_vec;
    logic [7:0]      r_chan_vec;
    logic [TS_W-1:0] r_start_ts;
    logic [7:0]      r_glitch;

    // Free-running cycle timestamp; clear does not restart it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + TS_ONE;
        end
    end

    // Confirmation FSM with registered report outputs; clear overrides all transitions.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= ST_IDLE;
            r_run          <= 16'd0;
            r_deadlock     <= 1'b0;
            r_report_valid <= 1'b0;
            r_axis_vec     <= 8'd0;
            r_chan_vec     <= 8'd0;
            r_start_ts     <= '0;
            r_glitch       <= 8'd0;
        end else if (clear) begin
            r_state        <= ST_IDLE;
            r_run          <= 16'd0;
            r_deadlock     <= 1'b0;
            r_report_valid <= 1'b0;
            r_axis_vec     <= 8'd0;
            r_chan_vec     <= 8'd0;
            r_start_ts     <= '0;
            r_glitch       <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (block_in) begin
                        r_state    <= ST_SUSPECT;
                        r_run      <= 16'd1;
                        r_start_ts <= r_ts;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SUSPECT: begin
                    if (!block_in) begin
                        r_state <= ST_IDLE;
                        r_run   <= 16'd0;
                        if (r_glitch != 8'hFF) begin
                            r_glitch <= r_glitch + 8'd1;
                        end else begin
                            r_glitch <= r_glitch;
                        end
                    end else if (r_run >= RUN_LAST) begin
                        r_state        <= ST_REPORT;
                        r_deadlock     <= 1'b1;
                        r_report_valid <= 1'b1;
                        r_axis_vec     <= axis_vec_in;
                        r_chan_vec     <= chan_vec_in;
                    end else begin
                        r_run <= r_run + 16'd1;
                    end
                end
                ST_REPORT: begin
                    if (report_ready) begin
                        r_state        <= ST_HALT;
                        r_report_valid <= 1'b0;
                    end else begin
                        r_state <= ST_REPORT;
                    end
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                default: begin
                    r_state        <= ST_IDLE;
                    r_run          <= 16'd0;
                    r_deadlock     <= 1'b0;
                    r_report_valid <= 1'b0;
                end
            endcase
        end
    end

    assign deadlock        = r_deadlock;
    assign report_valid    = r_report_valid;
    assign report_axis_vec = r_axis_vec;
    assign report_chan_vec = r_chan_vec;
    assign report_start_ts = r_start_ts;
    assign glitch_count    = r_glitch;

endmodule

// File: tb/tb_aesl_deadlock_confirm.sv
// Directed self-checking bench for aesl_deadlock_confirm (THRESHOLD=16, TS_W=32).
module tb_aesl_deadlock_confirm;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        block_in;
    logic [7:0]  axis_vec_in;
    logic [7:0]  chan_vec_in;
    logic        clear;
    logic        report_ready;
    logic        deadlock;
    logic        report_valid;
    logic [7:0]  report_axis_vec;
    logic [7:0]  report_chan_vec;
    logic [31:0] report_start_ts;
    logic [7:0]  glitch_count;

    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned tb_ts    = 0;

    aesl_deadlock_confirm #(.THRESHOLD(16), .TS_W(32)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .block_in        (block_in),
        .axis_vec_in     (axis_vec_in),
        .chan_vec_in     (chan_vec_in),
        .clear           (clear),
        .report_ready    (report_ready),
        .deadlock        (deadlock),
        .report_valid    (report_valid),
        .report_axis_vec (report_axis_vec),
        .report_chan_vec (report_chan_vec),
        .report_start_ts (report_start_ts),
        .glitch_count    (glitch_count)
    );

    always #5 clock = ~clock;

    // One rising edge, then settle 1 time unit past it.
    task automatic step();
        @(posedge clock);
        #1;
        tb_ts = tb_ts + 1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; block_in = 1'b0; axis_vec_in = 8'h00; chan_vec_in = 8'h00;
        clear = 1'b0; report_ready = 1'b0;
        #12;
        n_checks++;
        if ({deadlock, report_valid} !== 2'b00) begin
            n_errors++; $display("FAIL reset_flags: got %b want 00", {deadlock, report_valid});
        end
        n_checks++;
        if ({report_axis_vec, report_chan_vec, glitch_count} !== 24'h0) begin
            n_errors++; $display("FAIL reset_fields: got %h want 000000", {report_axis_vec, report_chan_vec, glitch_count});
        end
        n_checks++;
        if (report_start_ts !== 32'd0) begin
            n_errors++; $display("FAIL reset_ts: got %0d want 0", report_start_ts);
        end
        @(negedge clock);
        reset_n = 1'b1;
        tb_ts = 0;
        #4;
    endtask

    task automatic test_confirm();
        while (tb_ts < 10) step();
        block_in = 1'b1; axis_vec_in = 8'h81; chan_vec_in = 8'h7E;
        for (int i = 0; i < 15; i++) begin
            step();
            n_checks++;
            if (report_valid !== 1'b0 || deadlock !== 1'b0) begin
                n_errors++; $display("FAIL early_confirm: cycle %0d valid %b deadlock %b want 0 0", i, report_valid, deadlock);
            end
        end
        step();
        n_checks++;
        if ({deadlock, report_valid} !== 2'b11) begin
            n_errors++; $display("FAIL confirm_flags: got %b want 11", {deadlock, report_valid});
        end
        n_checks++;
        if (report_start_ts !== 32'd10) begin
            n_errors++; $display("FAIL confirm_start_ts: got %0d want 10", report_start_ts);
        end
        n_checks++;
        if (report_axis_vec !== 8'h81 || report_chan_vec !== 8'h7E) begin
            n_errors++; $display("FAIL confirm_vecs: got %h/%h want 81/7e", report_axis_vec, report_chan_vec);
        end
    endtask

    task automatic test_hold_and_handshake();
        report_ready = 1'b0;
        for (int i = 0; i < 50; i++) begin
            axis_vec_in = 8'($urandom); chan_vec_in = 8'($urandom); block_in = 1'($urandom);
            step();
            n_checks++;
            if (report_valid !== 1'b1 || report_axis_vec !== 8'h81 || report_chan_vec !== 8'h7E || report_start_ts !== 32'd10) begin
                n_errors++; $display("FAIL hold: cycle %0d valid %b vecs %h/%h ts %0d want 1 81/7e 10",
                                     i, report_valid, report_axis_vec, report_chan_vec, report_start_ts);
            end
        end
        report_ready = 1'b1;
        step();
        report_ready = 1'b0;
        n_checks++;
        if ({deadlock, report_valid} !== 2'b10) begin
            n_errors++; $display("FAIL handshake: deadlock/valid %b want 10", {deadlock, report_valid});
        end
        // HALT ignores block_in and report_ready.
        block_in = 1'b1;
        for (int i = 0; i < 20; i++) begin
            report_ready = 1'(i % 2);
            step();
            n_checks++;
            if ({deadlock, report_valid} !== 2'b10 || report_axis_vec !== 8'h81 || report_start_ts !== 32'd10) begin
                n_errors++; $display("FAIL halt_hold: cycle %0d flags %b axis %h ts %0d want 10 81 10",
                                     i, {deadlock, report_valid}, report_axis_vec, report_start_ts);
            end
        end
        report_ready = 1'b0;
    endtask

    task automatic test_clear_and_rearm();
        int unsigned exp_start;
        clear = 1'b1; block_in = 1'b1;
        step();
        clear = 1'b0;
        n_checks++;
        if ({deadlock, report_valid} !== 2'b00 || {report_axis_vec, report_chan_vec, glitch_count} !== 24'h0 || report_start_ts !== 32'd0) begin
            n_errors++; $display("FAIL clear: flags %b fields %h ts %0d want all zero",
                                 {deadlock, report_valid}, {report_axis_vec, report_chan_vec, glitch_count}, report_start_ts);
        end
        exp_start = tb_ts;
        axis_vec_in = 8'h3C; chan_vec_in = 8'hA5;
        for (int i = 0; i < 15; i++) step();
        n_checks++;
        if (report_valid !== 1'b0) begin
            n_errors++; $display("FAIL rearm_early: valid %b want 0", report_valid);
        end
        step();
        n_checks++;
        if ({deadlock, report_valid} !== 2'b11 || report_start_ts !== exp_start || report_axis_vec !== 8'h3C || report_chan_vec !== 8'hA5) begin
            n_errors++; $display("FAIL rearm_report: flags %b ts %0d vecs %h/%h want 11 %0d 3c/a5",
                                 {deadlock, report_valid}, report_start_ts, report_axis_vec, report_chan_vec, exp_start);
        end
        clear = 1'b1; block_in = 1'b0;
        step();
        clear = 1'b0;
    endtask

    task automatic test_glitch();
        report_ready = 1'b1;
        block_in = 1'b1;
        for (int i = 0; i < 15; i++) step();
        block_in = 1'b0;
        step();
        report_ready = 1'b0;
        n_checks++;
        if (glitch_count !== 8'd1 || {deadlock, report_valid} !== 2'b00) begin
            n_errors++; $display("FAIL glitch15: count %0d flags %b want 1 00", glitch_count, {deadlock, report_valid});
        end
    endtask

    task automatic test_saturate();
        for (int e = 0; e < 300; e++) begin
            block_in = 1'b1;
            repeat (3) step();
            block_in = 1'b0;
            step();
            if (e == 252) begin
                n_checks++;
                if (glitch_count !== 8'd254) begin
                    n_errors++; $display("FAIL glitch_254: count %0d want 254", glitch_count);
                end
            end
        end
        n_checks++;
        if (glitch_count !== 8'd255 || deadlock !== 1'b0 || report_valid !== 1'b0) begin
            n_errors++; $display("FAIL glitch_sat: count %0d deadlock %b valid %b want 255 0 0", glitch_count, deadlock, report_valid);
        end
    endtask

    task automatic test_reset_mid();
        int unsigned exp_start;
        block_in = 1'b1;
        repeat (12) step();
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({deadlock, report_valid, report_axis_vec, report_chan_vec, glitch_count} !== 26'h0 || report_start_ts !== 32'd0) begin
            n_errors++; $display("FAIL async_reset: glitch %0d start %0d flags %b want 0 0 00",
                                 glitch_count, report_start_ts, {deadlock, report_valid});
        end
        block_in = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        tb_ts = 0;
        #4;
        repeat (3) step();
        exp_start = tb_ts;
        block_in = 1'b1; axis_vec_in = 8'h55; chan_vec_in = 8'h0F;
        for (int i = 0; i < 15; i++) step();
        n_checks++;
        if (report_valid !== 1'b0 || glitch_count !== 8'd0) begin
            n_errors++; $display("FAIL post_reset_early: valid %b glitch %0d want 0 0", report_valid, glitch_count);
        end
        step();
        n_checks++;
        if ({deadlock, report_valid} !== 2'b11 || report_start_ts !== exp_start || report_axis_vec !== 8'h55) begin
            n_errors++; $display("FAIL post_reset_report: flags %b ts %0d axis %h want 11 %0d 55",
                                 {deadlock, report_valid}, report_start_ts, report_axis_vec, exp_start);
        end
    endtask

    initial begin
        test_reset();
        test_confirm();
        test_hold_and_handshake();
        test_clear_and_rearm();
        test_glitch();
        test_saturate();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
